// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between icache and dcache. The dcache has priority and its two-word blocks are locked.
// A starvation counter forces an icache grant once enough dcache words have completed while the icache was waiting.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     r_state;
   state_t     w_next;
   state_t     w_arb;
   logic [3:0] r_cnt;
   logic       w_dreq;
   logic       w_starve;
   logic       w_icomp;
   logic       w_dcomp;

   assign w_dreq   = dREN | dWEN;
   assign w_starve = (r_cnt >= LIMIT);
   assign w_icomp  = (r_state == IGNT) & ramready;
   assign w_dcomp  = (r_state == DGNT) & ramready;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_icomp || !iREN)
            r_cnt <= '0;
         else if (w_dcomp && (r_cnt < LIMIT))
            r_cnt <= r_cnt + 4'd1;
      end
   end

   always_comb begin
      w_arb = IDLE;
      if (w_starve && iREN)
         w_arb = IGNT;
      else if (w_dreq)
         w_arb = DGNT;
      else if (iREN)
         w_arb = IGNT;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: w_next = w_arb;
         IGNT: begin
            if (ramready)
               w_next = w_arb;
            else if (!iREN)
               w_next = IDLE;
         end
         DGNT: begin
            // First word of a block keeps the port so the second word follows with no gap, even when starving.
            if (ramready)
               w_next = (!daddr[2] && w_dreq) ? DGNT : w_arb;
            else if (!w_dreq)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (r_state)
         IGNT: begin
            ramREN  = iREN;
            ramaddr = iaddr;
         end
         DGNT: begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
         end
         default: ;
      endcase
      iwait = ~w_icomp;
      dwait = ~w_dcomp;
      iload = ramload;
      dload = ramload;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: one vector per clock cycle, outputs checked mid-cycle.
// Extra hand-written sequences cover reset values and an asynchronous reset during an access.
module tb_mem_arbiter;

   logic        CLK;
   logic        nRST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ramready;

   int unsigned checks = 0;
   int unsigned errors = 0;

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramready (ramready)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        iren;
      logic [31:0] iaddr;
      logic        dren;
      logic        dwen;
      logic [31:0] daddr;
      logic [31:0] dstore;
      logic        rdy;
      logic [31:0] rload;
      logic        e_iw;
      logic        e_dw;
      logic        e_ren;
      logic        e_wen;
      logic [31:0] e_addr;
      logic [31:0] e_store;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic iren, input logic [31:0] ia, input logic dren, input logic dwen,
                      input logic [31:0] da, input logic [31:0] ds, input logic rdy, input logic [31:0] rl,
                      input logic e_iw, input logic e_dw, input logic e_ren, input logic e_wen,
                      input logic [31:0] e_addr, input logic [31:0] e_store);
      vec_t v;
      v.iren = iren;  v.iaddr = ia;   v.dren = dren;   v.dwen = dwen;
      v.daddr = da;   v.dstore = ds;  v.rdy = rdy;     v.rload = rl;
      v.e_iw = e_iw;  v.e_dw = e_dw;  v.e_ren = e_ren; v.e_wen = e_wen;
      v.e_addr = e_addr; v.e_store = e_store;
      vecs.push_back(v);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      iREN     = v.iren;
      iaddr    = v.iaddr;
      dREN     = v.dren;
      dWEN     = v.dwen;
      daddr    = v.daddr;
      dstore   = v.dstore;
      ramready = v.rdy;
      ramload  = v.rload;
   endtask

   task automatic clear_inputs();
      iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
      daddr = '0; dstore = '0; ramready = 1'b0; ramload = '0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk1 ({tag, ".iwait"},    iwait,    1'b1);
      chk1 ({tag, ".dwait"},    dwait,    1'b1);
      chk1 ({tag, ".ramREN"},   ramREN,   1'b0);
      chk1 ({tag, ".ramWEN"},   ramWEN,   1'b0);
      chk32({tag, ".ramaddr"},  ramaddr,  32'h0);
      chk32({tag, ".ramstore"}, ramstore, 32'h0);
      chk32({tag, ".iload"},    iload,    ramload);
      chk32({tag, ".dload"},    dload,    ramload);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      // Lone icache read: strobe at cycle 1, completion two cycles later
      add(1,32'h100,0,0,0,0,0,0,                 1,1,0,0,32'h0,0);
      add(1,32'h100,0,0,0,0,0,0,                 1,1,1,0,32'h100,0);
      add(1,32'h100,0,0,0,0,0,0,                 1,1,1,0,32'h100,0);
      add(1,32'h100,0,0,0,0,1,32'hDEADBEEF,      0,1,1,0,32'h100,0);
      add(0,0,0,0,0,0,0,0,                       1,1,0,0,32'h0,0);
      add(0,0,0,0,0,0,1,0,                       1,1,0,0,32'h0,0);
      // Simultaneous first requests, dcache block write-back with icache pending
      add(1,32'h140,1,1,32'h200,32'hAAAA0001,0,0, 1,1,0,0,32'h0,0);
      add(1,32'h140,1,1,32'h200,32'hAAAA0001,0,0, 1,1,0,1,32'h200,32'hAAAA0001);
      add(1,32'h140,1,1,32'h200,32'hAAAA0001,1,0, 1,0,0,1,32'h200,32'hAAAA0001);
      add(1,32'h140,1,1,32'h204,32'hAAAA0002,0,0, 1,1,0,1,32'h204,32'hAAAA0002);
      add(1,32'h140,1,1,32'h204,32'hAAAA0002,1,0, 1,0,0,1,32'h204,32'hAAAA0002);
      add(1,32'h140,0,0,0,0,0,0,                 1,1,0,0,32'h0,0);
      add(1,32'h140,0,0,0,0,0,0,                 1,1,0,0,32'h0,0);
      add(1,32'h140,0,0,0,0,1,32'h12345678,      0,1,1,0,32'h140,0);
      add(0,0,0,0,0,0,0,0,                       1,1,0,0,32'h0,0);
      // Starvation: unlocked dcache reads until the counter saturates, then icache wins
      add(1,32'h180,1,0,32'h004,0,0,0,           1,1,0,0,32'h0,0);
      add(1,32'h180,1,0,32'h004,0,1,32'h11,      1,0,1,0,32'h004,0);
      add(1,32'h180,1,0,32'h00C,0,1,32'h22,      1,0,1,0,32'h00C,0);
      add(1,32'h180,1,0,32'h014,0,1,32'h33,      1,0,1,0,32'h014,0);
      add(1,32'h180,1,0,32'h01C,0,1,32'h44,      1,0,1,0,32'h01C,0);
      add(1,32'h180,1,0,32'h024,0,1,32'h55,      1,0,1,0,32'h024,0);
      add(1,32'h180,1,0,32'h02C,0,1,32'hCAFEF00D,0,1,1,0,32'h180,0);
      add(1,32'h184,1,0,32'h02C,0,1,32'h66,      0,1,1,0,32'h184,0);
      add(1,32'h188,1,0,32'h02C,0,1,32'h77,      1,0,1,0,32'h02C,0);
      add(0,0,0,0,0,0,0,0,                       1,1,0,0,32'h0,0);
      // Burst lock at 0x300 holds the port although the counter is saturated
      add(1,32'h1C0,1,0,32'h004,0,0,0,           1,1,0,0,32'h0,0);
      add(1,32'h1C0,1,0,32'h004,0,1,32'h1,       1,0,1,0,32'h004,0);
      add(1,32'h1C0,1,0,32'h00C,0,1,32'h2,       1,0,1,0,32'h00C,0);
      add(1,32'h1C0,1,0,32'h014,0,1,32'h3,       1,0,1,0,32'h014,0);
      add(1,32'h1C0,1,0,32'h01C,0,1,32'h4,       1,0,1,0,32'h01C,0);
      add(1,32'h1C0,1,0,32'h300,0,1,32'h5,       1,0,1,0,32'h300,0);
      add(1,32'h1C0,1,0,32'h304,0,1,32'h6,       1,0,1,0,32'h304,0);
      add(1,32'h1C0,0,0,0,32'h55,1,32'hBEEF,     0,1,1,0,32'h1C0,0);
      add(0,0,0,0,0,0,0,0,                       1,1,0,0,32'h0,0);
      // Aborts: owner drops its request before ramready, no wait pulse afterwards
      add(0,0,1,0,32'h400,0,0,0,                 1,1,0,0,32'h0,0);
      add(0,0,1,0,32'h400,0,0,0,                 1,1,1,0,32'h400,0);
      add(0,0,0,0,0,0,0,0,                       1,1,0,0,32'h0,0);
      add(0,0,0,0,0,0,1,0,                       1,1,0,0,32'h0,0);
      add(1,32'h500,0,0,0,0,0,0,                 1,1,0,0,32'h0,0);
      add(1,32'h500,0,0,0,0,0,0,                 1,1,1,0,32'h500,0);
      add(0,0,0,0,0,0,0,0,                       1,1,0,0,32'h0,0);
      add(0,0,0,0,0,0,1,0,                       1,1,0,0,32'h0,0);

      // Reset values with live requests on every input
      nRST = 1'b0;
      iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; dWEN = 1'b1;
      daddr = 32'h200; dstore = 32'h1234; ramready = 1'b1; ramload = 32'h0BADF00D;
      #3;
      chk_idle_outputs("reset");
      repeat (2) @(negedge CLK);
      clear_inputs();
      nRST = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge CLK);
         drive(vecs[i]);
         #2;
         chk1 ($sformatf("v%0d.iwait", i),    iwait,    vecs[i].e_iw);
         chk1 ($sformatf("v%0d.dwait", i),    dwait,    vecs[i].e_dw);
         chk1 ($sformatf("v%0d.ramREN", i),   ramREN,   vecs[i].e_ren);
         chk1 ($sformatf("v%0d.ramWEN", i),   ramWEN,   vecs[i].e_wen);
         chk32($sformatf("v%0d.ramaddr", i),  ramaddr,  vecs[i].e_addr);
         chk32($sformatf("v%0d.ramstore", i), ramstore, vecs[i].e_store);
         chk32($sformatf("v%0d.iload", i),    iload,    vecs[i].rload);
         chk32($sformatf("v%0d.dload", i),    dload,    vecs[i].rload);
      end

      // Asynchronous reset in the middle of a dcache write
      @(negedge CLK);
      clear_inputs();
      dWEN = 1'b1; daddr = 32'h600; dstore = 32'h77;
      @(negedge CLK);
      #2;
      chk1 ("midrst.pre.ramWEN",  ramWEN,  1'b1);
      chk32("midrst.pre.ramaddr", ramaddr, 32'h600);
      #1;
      nRST = 1'b0;
      ramready = 1'b1;
      #1;
      chk_idle_outputs("midrst");
      @(negedge CLK);
      clear_inputs();
      nRST = 1'b1;
      @(negedge CLK);
      dREN = 1'b1; daddr = 32'h700; ramready = 1'b1; ramload = 32'h99;
      #2;
      chk1 ("post.idle.dwait",  dwait,  1'b1);
      chk1 ("post.idle.ramREN", ramREN, 1'b0);
      @(negedge CLK);
      #2;
      chk1 ("post.dgnt.dwait",   dwait,   1'b0);
      chk1 ("post.dgnt.ramREN",  ramREN,  1'b1);
      chk32("post.dgnt.ramaddr", ramaddr, 32'h700);
      chk32("post.dgnt.dload",   dload,   32'h99);

      @(negedge CLK);
      clear_inputs();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
